// File: rtl/fetch_queue_unit_pkg.sv
// fetch_pkg: opcode constants, instruction-length decode and queue FSM states.
package fetch_pkg;
  localparam logic [7:0] OP_RET = 8'hC3, OP_NOP = 8'h90, OP_HLT = 8'hF4;
  localparam logic [7:0] OP_ADD = 8'h01, OP_MOV = 8'h89, OP_ADDI8 = 8'h83;
  localparam logic [7:0] OP_MOVI_AX = 8'hB8, OP_MOVI_CX = 8'hB9, OP_ADDI = 8'h05, OP_JMP = 8'hE9;
  typedef enum logic [1:0] {RUN, WAIT, DRAIN, HALTED} state_t;
  function automatic logic [2:0] len_decode(input logic [7:0] op);
    return (op == OP_ADD || op == OP_MOV) ? 3'd2 :
           (op == OP_ADDI8) ? 3'd3 :
           (op == OP_MOVI_AX || op == OP_MOVI_CX || op == OP_ADDI || op == OP_JMP) ? 3'd5 : 3'd1;
  endfunction
endpackage

// File: rtl/fetch_queue_unit_if.sv
// fetch_queue_unit_if: instruction-memory, redirect and decoder handshakes of the fetch queue.
interface fetch_queue_unit_if #(parameter int FETCH_BYTES = 8);
  logic imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr;
  logic [FETCH_BYTES*8-1:0] imem_rsp_data;
  logic redirect_valid;
  logic [31:0] redirect_target;
  logic dec_valid, dec_ready;
  logic [39:0] dec_instr;
  logic [31:0] dec_pc;
  logic [2:0] dec_len;
  modport master(output imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc, dec_len,
                 input imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_target, dec_ready);
  modport slave(input imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc, dec_len,
                output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_target, dec_ready);
endinterface

// File: rtl/fetch_queue_unit_len_decode.sv
// fetch_len_decode: combinational opcode to instruction-length lookup.
module fetch_len_decode import fetch_pkg::*; (
  input  logic [7:0] opcode,
  output logic [2:0] len
);
  assign len = len_decode(opcode);
endmodule

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: circular byte queue between instruction memory and a variable-length decoder.
// Optional FETCH_QUEUE_PERF_EN adds saturating instruction/starvation counters.
module fetch_queue_unit import fetch_pkg::*; #(
  parameter int FETCH_BYTES = 8,
  parameter int QUEUE_BYTES = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic clk,
  input logic rst_n,
  fetch_queue_unit_if.master bus
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0] perf_instr_cnt,
  output logic [31:0] perf_starve_cnt
`endif
);
  localparam int PW = $clog2(QUEUE_BYTES);
  localparam int CW = PW + 1;
  state_t state;
  logic outst, req_fire, dec_fire, halt_fire, append, busy;
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [31:0] fetch_pc, dec_pc;
  logic [7:0] q [QUEUE_BYTES];
  logic [7:0] opcode;
  logic [2:0] len;
  assign opcode = count != '0 ? q[head] : 8'h00;
  fetch_len_decode u_len (.opcode(opcode), .len(len));
  always_comb begin
    bus.dec_instr = '0;
    for (int i = 0; i < 5; i++)
      if (i < int'(len) && i < int'(count)) bus.dec_instr[8*i +: 8] = q[head + PW'(i)];
  end
  assign bus.dec_len = len;
  assign bus.dec_pc = dec_pc;
  assign bus.dec_valid = state != HALTED && count != '0 && count >= CW'(len);
  assign bus.imem_req_valid = rst_n && state == RUN && (CW'(QUEUE_BYTES) - count) >= CW'(FETCH_BYTES);
  assign bus.imem_req_addr = fetch_pc;
  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign dec_fire = bus.dec_valid && bus.dec_ready;
  assign halt_fire = dec_fire && opcode == OP_HLT;
  assign append = state == WAIT && bus.imem_rsp_valid && !halt_fire;
  assign busy = (outst && !bus.imem_rsp_valid) || req_fire;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      outst <= 1'b0;
      head <= '0;
      tail <= '0;
      count <= '0;
      fetch_pc <= RESET_PC;
      dec_pc <= RESET_PC;
    end else if (bus.redirect_valid) begin
      state <= busy ? DRAIN : RUN;
      outst <= busy;
      head <= '0;
      tail <= '0;
      count <= '0;
      fetch_pc <= bus.redirect_target;
      dec_pc <= bus.redirect_target;
    end else begin
      state <= halt_fire ? HALTED :
               (state == RUN && req_fire) ? WAIT :
               ((state == WAIT || state == DRAIN) && bus.imem_rsp_valid) ? RUN : state;
      outst <= busy;
      head <= head + (dec_fire ? PW'(len) : '0);
      tail <= tail + (append ? PW'(FETCH_BYTES) : '0);
      count <= count + (append ? CW'(FETCH_BYTES) : '0) - (dec_fire ? CW'(len) : '0);
      fetch_pc <= fetch_pc + (append ? 32'(FETCH_BYTES) : 32'd0);
      dec_pc <= dec_pc + (dec_fire ? 32'(len) : 32'd0);
    end
  always_ff @(posedge clk)
    if (append)
      for (int i = 0; i < FETCH_BYTES; i++) q[tail + PW'(i)] <= bus.imem_rsp_data[8*i +: 8];
`ifdef FETCH_QUEUE_PERF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_instr_cnt <= '0;
      perf_starve_cnt <= '0;
    end else begin
      if (dec_fire && !bus.redirect_valid && perf_instr_cnt != '1) perf_instr_cnt <= perf_instr_cnt + 32'd1;
      if (state != HALTED && !bus.dec_valid && perf_starve_cnt != '1) perf_starve_cnt <= perf_starve_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: memory responder, instruction-stream reference model and directed scenarios.
module tb_fetch_queue_unit;
  localparam int FB = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  fetch_queue_unit_if #(.FETCH_BYTES(FB)) bus ();
`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perf_instr_cnt, perf_starve_cnt;
`endif
  fetch_queue_unit #(.FETCH_BYTES(FB), .QUEUE_BYTES(16), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef FETCH_QUEUE_PERF_EN
    , .perf_instr_cnt(perf_instr_cnt), .perf_starve_cnt(perf_starve_cnt)
`endif
  );
  logic [7:0] mem [0:511];
  int errors = 0, checks = 0;
  int lat = 0, rsp_count = 0, rsp_at46 = -1;
  logic [31:0] exp_pc, exp_fetch, prev_addr, paddr;
  bit halted = 0, prev_stall = 0, pend = 0;
  int wait_c = 0;
  logic [31:0] f_pc[$], req_addrs[$];
  logic [2:0] f_len[$];
  logic [39:0] f_ins[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [2:0] ref_len(input logic [7:0] op);
    case (op)
      8'h01, 8'h89: return 3'd2;
      8'h83: return 3'd3;
      8'hB8, 8'hB9, 8'h05, 8'hE9: return 3'd5;
      default: return 3'd1;
    endcase
  endfunction
  function automatic logic [7:0] mb(input logic [31:0] a);
    return mem[a[8:0]];
  endfunction
  task automatic load(input logic [31:0] a, input logic [7:0] b[$]);
    foreach (b[i]) mem[a[8:0] + 9'(i)] = b[i];
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic redirect(input logic [31:0] a);
    bus.redirect_valid = 1'b1;
    bus.redirect_target = a;
    tick();
    bus.redirect_valid = 1'b0;
  endtask
  task automatic wait_halt(input string name);
    int n = 0;
    while (!halted && n < 200) begin
      tick();
      n++;
    end
    chk({name, "_halted"}, 64'(halted), 64'd1);
    repeat (4) tick();
  endtask
  task automatic wait_req(input string name);
    int n = 0;
    int s = req_addrs.size();
    while (req_addrs.size() == s && n < 50) begin
      tick();
      n++;
    end
    chk({name, "_req_seen"}, 64'(req_addrs.size() > s), 64'd1);
  endtask
  task automatic clear_log();
    f_pc.delete();
    f_len.delete();
    f_ins.delete();
  endtask

  // memory: one outstanding request, answered lat cycles after acceptance
  initial begin
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.imem_req_valid && bus.imem_req_ready) begin
        pend = 1;
        paddr = bus.imem_req_addr;
        wait_c = lat;
      end
      @(posedge clk);
      #1;
      bus.imem_rsp_valid = 1'b0;
      if (!rst_n) pend = 0;
      else if (pend) begin
        if (wait_c == 0) begin
          bus.imem_rsp_valid = 1'b1;
          for (int i = 0; i < FB; i++) bus.imem_rsp_data[8*i +: 8] = mb(paddr + 32'(i));
          pend = 0;
          rsp_count++;
        end else wait_c--;
      end
    end
  end

  // reference: the decoder sees the program as a byte stream walked from the current pc
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      exp_pc = 32'h0;
      exp_fetch = 32'h0;
      halted = 0;
      prev_stall = 0;
    end else begin
      logic [2:0] l;
      logic [39:0] ins;
      if (bus.imem_req_valid && prev_stall) chk("req_addr_hold", bus.imem_req_addr, prev_addr);
      if (halted) begin
        chk("halted_req_valid", 64'(bus.imem_req_valid), 64'd0);
        chk("halted_dec_valid", 64'(bus.dec_valid), 64'd0);
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        chk("req_addr", bus.imem_req_addr, exp_fetch);
        req_addrs.push_back(bus.imem_req_addr);
        exp_fetch += FB;
      end
      if (bus.dec_valid) begin
        l = ref_len(mb(exp_pc));
        ins = '0;
        for (int i = 0; i < 5; i++) if (i < int'(l)) ins[8*i +: 8] = mb(exp_pc + 32'(i));
        chk("dec_pc", bus.dec_pc, exp_pc);
        chk("dec_len", 64'(bus.dec_len), 64'(l));
        chk("dec_instr", bus.dec_instr, ins);
        if (exp_pc == 32'h46 && rsp_at46 < 0) rsp_at46 = rsp_count;
        if (bus.dec_ready && !bus.redirect_valid) begin
          f_pc.push_back(exp_pc);
          f_len.push_back(l);
          f_ins.push_back(ins);
          if (mb(exp_pc) == 8'hF4) halted = 1;
          exp_pc += 32'(l);
        end
      end
      if (bus.redirect_valid) begin
        exp_pc = bus.redirect_target;
        exp_fetch = bus.redirect_target;
        halted = 0;
      end
      prev_stall = bus.imem_req_valid && !bus.imem_req_ready && !bus.redirect_valid;
      prev_addr = bus.imem_req_addr;
    end
  end

  initial begin
    int e_pc[5] = '{0, 1, 2, 4, 9};
    int e_len[5] = '{1, 1, 2, 5, 1};
    int n, k, base;
    bit found;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = '0;
    bus.dec_ready = 1'b1;
    bus.imem_req_ready = 1'b1;
    foreach (mem[i]) mem[i] = 8'h00;
    load(32'h000, '{8'h90, 8'h90, 8'h01, 8'hC0, 8'hB8, 8'h78, 8'h56, 8'h34, 8'h12, 8'hF4});
    load(32'h040, '{8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'hB8, 8'h78, 8'h56, 8'h34, 8'h12, 8'hF4});
    load(32'h080, '{8'h83, 8'hAA, 8'hBB, 8'h89, 8'hC0, 8'h90, 8'hB9, 8'h11, 8'h22, 8'h33, 8'h44, 8'hC3,
                    8'h05, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'hD8, 8'hE9, 8'h10, 8'h00, 8'h00, 8'h00,
                    8'h42, 8'hF4});
    load(32'h100, '{8'hB8, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hF4});
    for (int i = 32'h140; i < 32'h180; i++) mem[i] = 8'h90;
    load(32'h180, '{8'hC3, 8'hF4});
    repeat (3) @(negedge clk);
    chk("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
    chk("rst_dec_valid", 64'(bus.dec_valid), 64'd0);
    chk("rst_dec_instr", bus.dec_instr, 64'd0);
    chk("rst_dec_len", 64'(bus.dec_len), 64'd1);
    chk("rst_dec_pc", bus.dec_pc, 64'd0);
    tick();
    rst_n = 1'b1;
    // straight-line program ending in halt
    wait_halt("t030");
    chk("t030_fires", f_pc.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk("t030_pc", f_pc[i], 64'(e_pc[i]));
      chk("t030_len", 64'(f_len[i]), 64'(e_len[i]));
    end
    chk("t030_movi", f_ins[3], 40'h12345678B8);
    n = req_addrs.size();
    repeat (10) tick();
    chk("t030_no_req", req_addrs.size(), n);
`ifdef FETCH_QUEUE_PERF_EN
    chk("t030_perf_instr", perf_instr_cnt, 5);
`endif
    // 5-byte instruction straddling two fetches
    clear_log();
    base = rsp_count;
    redirect(32'h40);
    wait_halt("t031");
    chk("t031_fires", f_pc.size(), 8);
    chk("t031_pc", f_pc[6], 32'h46);
    chk("t031_len", 64'(f_len[6]), 5);
    chk("t031_instr", f_ins[6], 40'h12345678B8);
    chk("t031_two_rsp", 64'(rsp_at46 - base >= 2), 1);
    // decoder backpressure fills the queue
    clear_log();
    bus.dec_ready = 1'b0;
    redirect(32'h80);
    repeat (20) tick();
    chk("t032_req_valid", 64'(bus.imem_req_valid), 0);
    chk("t032_dec_valid", 64'(bus.dec_valid), 1);
    chk("t032_dec_pc", bus.dec_pc, 32'h80);
    chk("t032_dec_instr", bus.dec_instr, 40'h0000BBAA83);
    bus.dec_ready = 1'b1;
    wait_halt("t032");
    chk("t032_fires", f_pc.size(), 10);
    chk("t032_pc3", f_pc[3], 32'h86);
    chk("t032_ins3", f_ins[3], 40'h44332211B9);
    chk("t032_last_pc", f_pc[9], 32'h99);
    chk("t032_final_pc", bus.dec_pc, 32'h9A);
    // redirect while a fetch is in flight
    clear_log();
    lat = 3;
    bus.imem_req_ready = 1'b0;
    redirect(32'h20);
    repeat (3) tick();
    chk("t033_stall_valid", 64'(bus.imem_req_valid), 1);
    chk("t033_stall_addr", bus.imem_req_addr, 32'h20);
    bus.imem_req_ready = 1'b1;
    wait_req("t033");
    n = req_addrs.size();
    redirect(32'h100);
    wait_halt("t033");
    chk("t033_req_addr", req_addrs[n], 32'h100);
    chk("t033_first_pc", f_pc[0], 32'h100);
    chk("t033_first_ins", f_ins[0], 40'hDEADBEEFB8);
    // redirect colliding with a decode fire and a response
    clear_log();
    lat = 2;
    redirect(32'h140);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(posedge clk);
      #2;
      found = bus.imem_rsp_valid && bus.dec_valid && bus.dec_ready;
    end
    chk("t034_collision", 64'(found), 1);
    k = f_pc.size();
    n = req_addrs.size();
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'h180;
    tick();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("t034_empty", 64'(bus.dec_valid), 0);
    chk("t034_dec_pc", bus.dec_pc, 32'h180);
    tick();
    wait_halt("t034");
    chk("t034_first_pc", f_pc[k], 32'h180);
    chk("t034_req_addr", req_addrs[n], 32'h180);
    // reset while waiting on memory
    clear_log();
    lat = 5;
    redirect(32'h1C0);
    wait_req("t025");
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("t025_rst_req_valid", 64'(bus.imem_req_valid), 0);
`ifdef FETCH_QUEUE_PERF_EN
    chk("t025_perf_instr", perf_instr_cnt, 0);
    chk("t025_perf_starve", perf_starve_cnt, 0);
`endif
    tick();
    tick();
    lat = 0;
    n = req_addrs.size();
    rst_n = 1'b1;
    wait_halt("t025");
    chk("t025_req_addr", req_addrs[n], 32'h0);
    chk("t025_fires", f_pc.size(), 5);
    chk("t025_last_pc", f_pc[4], 32'h9);
`ifdef FETCH_QUEUE_PERF_EN
    chk("t025_perf_instr_run", perf_instr_cnt, 5);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_queue_unit.md
FETCH_QUEUE_UNIT -- requirements
Module: fetch_queue_unit

Interface
REQ-001 SHALL have parameter FETCH_BYTES, default 8, bytes returned per instruction-memory access (power of two, 4..16).
REQ-002 SHALL have parameter QUEUE_BYTES, default 16, byte-queue capacity (power of two, >= 2*FETCH_BYTES).
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-004 SHALL have ports: clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset; asynchronous, active-low.
REQ-006 imem_req_valid  out  1  fetch request; imem_req_addr  out  32  byte address, unaligned allowed; imem_req_ready  in  1  request accepted.
REQ-007 imem_rsp_valid  in  1  response; imem_rsp_data  in  FETCH_BYTES*8  bytes at addr..addr+FETCH_BYTES-1, little-endian (byte 0 in bits 7:0).
REQ-008 redirect_valid  in  1  taken jump/flush; redirect_target  in  32  new fetch PC.
REQ-009 dec_valid  out  1  instruction available; dec_ready  in  1  decoder accepts.
REQ-010 dec_instr  out  40  head 5 queue bytes, opcode in 7:0, bytes beyond length zero; dec_pc  out  32  instruction address; dec_len  out  3  length 1..5.

Function
REQ-011 Length SHALL be decoded from dec_instr[7:0]: C3/90/F4 -> 1; 01/89 -> 2; 83 -> 3; B8/B9/05/E9 -> 5; all others -> 1.
REQ-012 Queue SHALL be circular: head/tail pointers wrap modulo QUEUE_BYTES; count 0..QUEUE_BYTES.
REQ-013 States SHALL be RUN, WAIT, DRAIN, HALTED; reset state RUN.
REQ-014 RUN: imem_req_valid=1 iff QUEUE_BYTES-count >= FETCH_BYTES; req fire (valid&ready) -> WAIT, at most one outstanding.
REQ-015 WAIT: imem_req_valid=0; on imem_rsp_valid, append FETCH_BYTES bytes at tail, fetch_pc += FETCH_BYTES (mod 2^32), -> RUN.
REQ-016 dec_valid SHALL be 1 iff state != HALTED and count >= 1 and count >= decoded length; zero latency from queue contents.
REQ-017 On dec fire: head += dec_len, count -= dec_len, dec_pc += dec_len; append and consume in same cycle SHALL net correctly.
REQ-018 Dec fire of opcode F4 SHALL enter HALTED: no requests, dec_valid=0; a pending response is discarded.
REQ-019 redirect_valid SHALL take priority over all events: count=0, head=tail=0, fetch_pc=dec_pc=redirect_target; next state DRAIN if a request is outstanding and no response this cycle, else RUN; a simultaneous dec fire is ignored.
REQ-020 DRAIN: imem_req_valid=0; discard next response, -> RUN; a further redirect while in DRAIN stays in DRAIN.
REQ-021 dec_valid, dec_instr, dec_pc, dec_len SHALL hold stable while dec_valid=1 and dec_ready=0, absent redirect.
REQ-022 imem_req_addr SHALL hold stable while imem_req_valid=1 and imem_req_ready=0.
REQ-023 Response in RUN or HALTED with none outstanding SHALL be ignored.

Reset
REQ-024 While rst_n=0: state RUN, count 0, pointers 0, fetch_pc=dec_pc=RESET_PC, imem_req_valid=0, dec_valid=0, dec_instr=0, dec_len=1.
REQ-025 Reset mid-WAIT SHALL abandon the outstanding request; first request after release SHALL be at RESET_PC.

Configuration
REQ-026 Macro FETCH_QUEUE_PERF_EN defined: 32-bit outputs perf_instr_cnt (dec fires) and perf_starve_cnt (cycles with state RUN/WAIT/DRAIN and dec_valid=0), saturating, cleared by reset and not by redirect.
REQ-027 Macro undefined: perf ports and counters SHALL not exist; other behaviour identical.

Structure
REQ-028 Package fetch_pkg SHALL hold opcode constants, length-decode function, and state enum.
REQ-029 Sub-module fetch_len_decode (8-bit opcode -> 3-bit length, combinational) SHALL be instantiated once.

Verification
REQ-030 Reset, memory 90 90 01 C0 B8 78 56 34 12 F4, dec_ready=1 -> dec_pc 0,1,2,4,9 with lengths 1,1,2,5,1, then HALTED, no further requests.
REQ-031 B8 at byte 6 of an 8-byte fetch -> dec_valid=0 until the second response, then dec_instr=40'h12345678B8, len 5.
REQ-032 dec_ready=0 for 20 cycles -> count reaches 16, imem_req_valid=0, outputs stable; release -> in-order delivery, no loss.
REQ-033 Redirect to 32'h100 during WAIT -> stale response dropped, next request addr 32'h100, first dec_pc 32'h100.
REQ-034 Redirect in the same cycle as dec fire and response -> queue empty, dec_pc=target, response discarded.
REQ-035 With FETCH_QUEUE_PERF_EN, REQ-030 run -> perf_instr_cnt=5; rst_n pulse mid-WAIT -> counters 0, next request at RESET_PC.
